// File: rtl/clock_pkg.sv
// Shared constants and key-state encoding for the digital-clock front end,
// reused by clock, cnt_seg_dync and key_debounce_bank.
package clock_pkg;

  localparam int CLK_HZ     = 50_000_000;
  localparam int MS_CYCLES  = CLK_HZ / 1000;

  localparam int DB_CNT_DEF   = 20 * MS_CYCLES;
  localparam int LONG_CNT_DEF = 1000 * MS_CYCLES;
  localparam int RPT_CNT_DEF  = 200 * MS_CYCLES;
  localparam int SCAN_CNT_DEF = MS_CYCLES;

  // Enum form kept for readable waveforms; FSMs store the plain vector codes below.
  typedef enum logic [2:0] {
    KS_IDLE       = 3'd0,
    KS_PRESS_DB   = 3'd1,
    KS_HELD       = 3'd2,
    KS_REPEAT     = 3'd3,
    KS_RELEASE_DB = 3'd4
  } key_state_e;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_PRESS_DB   = 3'd1;
  localparam logic [2:0] ST_HELD       = 3'd2;
  localparam logic [2:0] ST_REPEAT     = 3'd3;
  localparam logic [2:0] ST_RELEASE_DB = 3'd4;

  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/key_debounce_bank_if.sv
// Raw push-button inputs and conditioned control outputs of the key front end.
interface key_debounce_bank_if;

  logic key_mod;
  logic key_alarm;
  logic key_add;
  logic key_loc;
  logic set_mod;
  logic set_alarm;
  logic time_add;
  logic set_location;

  modport master (
    output key_mod, key_alarm, key_add, key_loc,
    input  set_mod, set_alarm, time_add, set_location
  );

  modport slave (
    input  key_mod, key_alarm, key_add, key_loc,
    output set_mod, set_alarm, time_add, set_location
  );

endinterface

// File: rtl/key_debounce_bank_key_fsm.sv
// One key channel: 2-FF synchronizer, debounce/hold/repeat FSM and its counter.
// evt is combinational so the parent can register it straight into an output.
module key_fsm
  import clock_pkg::*;
#(
  parameter int   DB_CNT    = DB_CNT_DEF,
  parameter int   LONG_CNT  = LONG_CNT_DEF,
  parameter int   RPT_CNT   = RPT_CNT_DEF,
  parameter logic KEY_ACT   = 1'b0,
  parameter bit   REPEAT_EN = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  output logic evt
);

  localparam int CW = cnt_width(LONG_CNT);
  localparam logic [CW-1:0] DB_LAST   = CW'(DB_CNT - 1);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CNT - 1);
  localparam logic [CW-1:0] RPT_LAST  = CW'(RPT_CNT - 1);

  logic          sync1_q, sync2_q;
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pressed;

  assign pressed = (sync2_q == KEY_ACT);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    evt     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pressed) begin
          state_d = ST_PRESS_DB;
          cnt_d   = '0;
        end
      end
      ST_PRESS_DB: begin
        if (!pressed) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = ST_HELD;
          cnt_d   = '0;
          evt     = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_HELD: begin
        // Release is checked first so a key let go on the threshold never repeats.
        if (!pressed) begin
          state_d = ST_RELEASE_DB;
          cnt_d   = '0;
        end else if (cnt_q == LONG_LAST) begin
          if (REPEAT_EN) begin
            state_d = ST_REPEAT;
            cnt_d   = '0;
            evt     = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_REPEAT: begin
        if (!pressed) begin
          state_d = ST_RELEASE_DB;
          cnt_d   = '0;
        end else if (cnt_q == RPT_LAST) begin
          cnt_d = '0;
          evt   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_RELEASE_DB: begin
        // A bounce on release falls back to HELD silently instead of re-pressing.
        if (pressed) begin
          state_d = ST_HELD;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= ~KEY_ACT;
      sync2_q <= ~KEY_ACT;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      sync1_q <= key_raw;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/key_debounce_bank.sv
// Key front end: four debounced key channels mapped onto the mode levels
// and the increment / calibration-advance pulses.
module key_debounce_bank
  import clock_pkg::*;
#(
  parameter int   DB_CNT   = DB_CNT_DEF,
  parameter int   LONG_CNT = LONG_CNT_DEF,
  parameter int   RPT_CNT  = RPT_CNT_DEF,
  parameter logic KEY_ACT  = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  key_debounce_bank_if.slave  bus
);

  logic evt_mod, evt_alarm, evt_add, evt_loc;
  logic set_mod_q, set_mod_d;
  logic set_alarm_q, set_alarm_d;
  logic time_add_q, time_add_d;
  logic set_location_q, set_location_d;

  key_fsm #(.DB_CNT(DB_CNT), .LONG_CNT(LONG_CNT), .RPT_CNT(RPT_CNT),
            .KEY_ACT(KEY_ACT), .REPEAT_EN(1'b0))
    u_mod (.clk(clk), .rst_n(rst_n), .key_raw(bus.key_mod), .evt(evt_mod));

  key_fsm #(.DB_CNT(DB_CNT), .LONG_CNT(LONG_CNT), .RPT_CNT(RPT_CNT),
            .KEY_ACT(KEY_ACT), .REPEAT_EN(1'b0))
    u_alarm (.clk(clk), .rst_n(rst_n), .key_raw(bus.key_alarm), .evt(evt_alarm));

  key_fsm #(.DB_CNT(DB_CNT), .LONG_CNT(LONG_CNT), .RPT_CNT(RPT_CNT),
            .KEY_ACT(KEY_ACT), .REPEAT_EN(1'b1))
    u_add (.clk(clk), .rst_n(rst_n), .key_raw(bus.key_add), .evt(evt_add));

  key_fsm #(.DB_CNT(DB_CNT), .LONG_CNT(LONG_CNT), .RPT_CNT(RPT_CNT),
            .KEY_ACT(KEY_ACT), .REPEAT_EN(1'b0))
    u_loc (.clk(clk), .rst_n(rst_n), .key_raw(bus.key_loc), .evt(evt_loc));

  // Mode and alarm-set are mutually exclusive; a tie goes to the mode key.
  always_comb begin
    set_mod_d      = set_mod_q;
    set_alarm_d    = set_alarm_q;
    time_add_d     = evt_add;
    set_location_d = evt_loc;
    if (evt_mod) begin
      set_mod_d   = !set_mod_q;
      set_alarm_d = 1'b0;
    end else if (evt_alarm) begin
      set_alarm_d = !set_alarm_q;
      set_mod_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      set_mod_q      <= 1'b0;
      set_alarm_q    <= 1'b0;
      time_add_q     <= 1'b0;
      set_location_q <= 1'b0;
    end else begin
      set_mod_q      <= set_mod_d;
      set_alarm_q    <= set_alarm_d;
      time_add_q     <= time_add_d;
      set_location_q <= set_location_d;
    end
  end

  assign bus.set_mod      = set_mod_q;
  assign bus.set_alarm    = set_alarm_q;
  assign bus.time_add     = time_add_q;
  assign bus.set_location = set_location_q;

endmodule

// File: tb/tb_key_debounce_bank.sv
// Directed bench for key_debounce_bank with DB_CNT=4, LONG_CNT=20, RPT_CNT=8,
// active-low keys. Cycle c is observed 1 time unit after the c-th clock edge
// following the moment the stimulus is applied.
module tb_key_debounce_bank;
  import clock_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  key_debounce_bank_if bus();

  always #5 clk = ~clk;

  key_debounce_bank #(.DB_CNT(4), .LONG_CNT(20), .RPT_CNT(8), .KEY_ACT(1'b0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string      name;
    logic [3:0] mask;   // {mod, alarm, add, loc}, 1 = pressed
    int         hold;
    int         n_add;
    int         n_loc;
    logic       mod_e;
    logic       alarm_e;
    int         first;  // first cycle any output reacts, -1 = never
  } vec_t;

  vec_t tbl[12];
  int   checks = 0;
  int   failures = 0;
  int   r_add, r_loc, r_first, r_mod_rise, r_mod_rise_cyc;
  int   add_at[$];
  logic mod0, alarm0, prev_mod;
  int   exp_rpt[5] = '{7, 27, 35, 43, 51};

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic all_idle();
    return (dut.u_mod.state_q == ST_IDLE) && (dut.u_alarm.state_q == ST_IDLE) &&
           (dut.u_add.state_q == ST_IDLE) && (dut.u_loc.state_q == ST_IDLE);
  endfunction

  task automatic drive(input logic [3:0] m);
    bus.key_mod   = !m[3];
    bus.key_alarm = !m[2];
    bus.key_add   = !m[1];
    bus.key_loc   = !m[0];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    r_add = 0; r_loc = 0; r_first = -1; r_mod_rise = 0; r_mod_rise_cyc = -1;
    add_at.delete();
    mod0 = bus.set_mod; alarm0 = bus.set_alarm; prev_mod = bus.set_mod;
  endtask

  task automatic observe(input int c);
    if (bus.time_add) begin
      r_add++;
      add_at.push_back(c);
    end
    if (bus.set_location) r_loc++;
    if (bus.set_mod && !prev_mod) begin
      r_mod_rise++;
      if (r_mod_rise_cyc < 0) r_mod_rise_cyc = c;
    end
    prev_mod = bus.set_mod;
    if (r_first < 0 && (bus.time_add || bus.set_location ||
                        bus.set_mod != mod0 || bus.set_alarm != alarm0))
      r_first = c;
  endtask

  task automatic apply(input logic [3:0] m, input int hold, input int tail);
    clear_obs();
    drive(m);
    for (int c = 1; c <= hold + tail; c++) begin
      step();
      observe(c);
      if (c == hold) drive(4'b0000);
    end
  endtask

  initial begin
    tbl[0]  = '{"loc_press",     4'b0001, 10, 0, 1, 1'b0, 1'b0,  7};
    tbl[1]  = '{"loc_glitch3",   4'b0001,  3, 0, 0, 1'b0, 1'b0, -1};
    tbl[2]  = '{"loc_short4",    4'b0001,  4, 0, 0, 1'b0, 1'b0, -1};
    tbl[3]  = '{"loc_min5",      4'b0001,  5, 0, 1, 1'b0, 1'b0,  7};
    tbl[4]  = '{"add_clean",     4'b0010, 20, 1, 0, 1'b0, 1'b0,  7};
    tbl[5]  = '{"add_loc_pair",  4'b0011, 10, 1, 1, 1'b0, 1'b0,  7};
    tbl[6]  = '{"mod_on",        4'b1000, 10, 0, 0, 1'b1, 1'b0,  7};
    tbl[7]  = '{"alarm_on",      4'b0100, 10, 0, 0, 1'b0, 1'b1,  7};
    tbl[8]  = '{"mod_alarm_tie", 4'b1100, 10, 0, 0, 1'b1, 1'b0,  7};
    tbl[9]  = '{"mod_off",       4'b1000, 10, 0, 0, 1'b0, 1'b0,  7};
    tbl[10] = '{"alarm_on2",     4'b0100, 10, 0, 0, 1'b0, 1'b1,  7};
    tbl[11] = '{"alarm_off",     4'b0100, 10, 0, 0, 1'b0, 1'b0,  7};

    // Reset state
    rst_n = 1'b0;
    drive(4'b0000);
    repeat (3) step();
    check("rst_set_mod", int'(bus.set_mod), 0);
    check("rst_set_alarm", int'(bus.set_alarm), 0);
    check("rst_time_add", int'(bus.time_add), 0);
    check("rst_set_location", int'(bus.set_location), 0);
    check("rst_fsm_idle", int'(all_idle()), 1);
    rst_n = 1'b1;
    repeat (5) step();
    check("idle_after_rst", int'({bus.set_mod, bus.set_alarm, bus.time_add, bus.set_location}), 0);

    // Table-driven presses; each entry runs from IDLE and ends back in IDLE
    for (int i = 0; i < 12; i++) begin
      apply(tbl[i].mask, tbl[i].hold, 20);
      check({tbl[i].name, "_n_add"}, r_add, tbl[i].n_add);
      check({tbl[i].name, "_n_loc"}, r_loc, tbl[i].n_loc);
      check({tbl[i].name, "_set_mod"}, int'(bus.set_mod), int'(tbl[i].mod_e));
      check({tbl[i].name, "_set_alarm"}, int'(bus.set_alarm), int'(tbl[i].alarm_e));
      check({tbl[i].name, "_first_cyc"}, r_first, tbl[i].first);
      check({tbl[i].name, "_idle"}, int'(all_idle()), 1);
    end

    // Auto-repeat: released just early enough that the next repeat (cycle 59) is not reached
    apply(4'b0010, 56, 30);
    check("rpt_count", r_add, 5);
    for (int i = 0; i < 5; i++)
      check($sformatf("rpt_pulse%0d_cyc", i), (add_at.size() > i) ? add_at[i] : -1, exp_rpt[i]);
    check("rpt_idle", int'(all_idle()), 1);

    // Bounce on mod for 10 cycles, then a steady press from cycle 10
    clear_obs();
    for (int c = 0; c < 70; c++) begin
      if (c < 10)      drive((c % 2 == 0) ? 4'b1000 : 4'b0000);
      else if (c < 50) drive(4'b1000);
      else             drive(4'b0000);
      step();
      observe(c + 1);
    end
    check("bounce_mod_rises", r_mod_rise, 1);
    check("bounce_mod_rise_cyc", r_mod_rise_cyc, 17);
    check("bounce_set_mod", int'(bus.set_mod), 1);
    apply(4'b1000, 10, 20);
    check("second_press_set_mod", int'(bus.set_mod), 0);

    // Release bounce: a 2-cycle gap inside a press must not re-trigger
    clear_obs();
    for (int c = 0; c < 45; c++) begin
      drive((c < 10 || (c >= 12 && c < 22)) ? 4'b0010 : 4'b0000);
      step();
      observe(c + 1);
    end
    check("relbounce_n_add", r_add, 1);
    check("relbounce_cyc", (add_at.size() > 0) ? add_at[0] : -1, 7);
    check("relbounce_idle", int'(all_idle()), 1);

    // Reset in the middle of an add press, with set_mod previously set
    apply(4'b1000, 10, 20);
    check("pre_rst_set_mod", int'(bus.set_mod), 1);
    drive(4'b0010);
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    check("midrst_set_mod", int'(bus.set_mod), 0);
    check("midrst_others", int'({bus.set_alarm, bus.time_add, bus.set_location}), 0);
    step();
    step();
    check("midrst_hold_outputs", int'({bus.set_mod, bus.set_alarm, bus.time_add, bus.set_location}), 0);
    rst_n = 1'b1;
    clear_obs();
    for (int c = 1; c <= 20; c++) begin
      step();
      observe(c);
    end
    check("postrst_n_add", r_add, 1);
    check("postrst_cyc", (add_at.size() > 0) ? add_at[0] : -1, 7);
    drive(4'b0000);
    repeat (20) step();
    check("final_idle", int'(all_idle()), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
